// File: rtl/control_unit.sv
// Multicycle MIPS-subset control FSM: fetch, decode, execute,
// memory access and writeback sequencing for the cpu datapath.
module control_unit #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       Zero,
    input  logic       Overflow,
    output logic       PCwrite,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemToReg,
    output logic       RegDest,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ShiftControl,
    output logic       ShiftToReg,
    output logic       IllegalOp,
    output logic [4:0] State
);

    typedef enum logic [4:0] {
        S_RESET    = 5'd0,
        S_FETCH    = 5'd1,
        S_FWAIT    = 5'd2,
        S_DECODE   = 5'd3,
        S_EXEC_R   = 5'd4,
        S_WB_R     = 5'd5,
        S_SH_LOAD  = 5'd6,
        S_SH_EXEC  = 5'd7,
        S_SH_WB    = 5'd8,
        S_ADDI_EX  = 5'd9,
        S_ADDI_WB  = 5'd10,
        S_MEM_ADDR = 5'd11,
        S_LW_RD    = 5'd12,
        S_LW_WB    = 5'd13,
        S_SW_WR    = 5'd14,
        S_BRANCH   = 5'd15,
        S_JUMP     = 5'd16
    } state_t;

    // Fetch wait needs at least one cycle so IRWrite always fires;
    // a load read spends one address cycle plus MEM_WAIT wait cycles.
    localparam logic [1:0] FW_LAST =
        (MEM_WAIT == 0) ? 2'd0 : 2'(MEM_WAIT - 1);
    localparam logic [1:0] LW_LAST = 2'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [2:0] alu_q, sh_q;
    logic       ovf_q, sw_q, bne_q;

    state_t     dec_next;
    logic       dec_ill;
    logic [2:0] dec_alu, dec_sh;
    logic       dec_ovf, dec_sw, dec_bne;

    // Instruction dispatch table from opcode/funct
    always_comb begin
        dec_next = S_FETCH;
        dec_ill  = 1'b0;
        dec_alu  = 3'b001;
        dec_sh   = 3'b000;
        dec_ovf  = 1'b0;
        dec_sw   = 1'b0;
        dec_bne  = 1'b0;
        unique case (OPCODE)
            6'h00: begin
                unique case (FUNCT)
                    6'h20: begin
                        dec_next = S_EXEC_R;
                        dec_ovf  = 1'b1;
                    end
                    6'h22: begin
                        dec_next = S_EXEC_R;
                        dec_alu  = 3'b010;
                        dec_ovf  = 1'b1;
                    end
                    6'h24: begin
                        dec_next = S_EXEC_R;
                        dec_alu  = 3'b011;
                    end
                    6'h00: begin
                        dec_next = S_SH_LOAD;
                        dec_sh   = 3'b010;
                    end
                    6'h02: begin
                        dec_next = S_SH_LOAD;
                        dec_sh   = 3'b011;
                    end
                    6'h03: begin
                        dec_next = S_SH_LOAD;
                        dec_sh   = 3'b100;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            6'h08: dec_next = S_ADDI_EX;
            6'h23: dec_next = S_MEM_ADDR;
            6'h2b: begin
                dec_next = S_MEM_ADDR;
                dec_sw   = 1'b1;
            end
            6'h04: dec_next = S_BRANCH;
            6'h05: begin
                dec_next = S_BRANCH;
                dec_bne  = 1'b1;
            end
            6'h02: dec_next = S_JUMP;
            default: dec_ill = 1'b1;
        endcase
    end

    // State, wait counter and decoded-instruction registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
            cnt_q   <= 2'd0;
            alu_q   <= 3'b000;
            sh_q    <= 3'b000;
            ovf_q   <= 1'b0;
            sw_q    <= 1'b0;
            bne_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_DECODE) begin
                alu_q <= dec_alu;
                sh_q  <= dec_sh;
                ovf_q <= dec_ovf;
                sw_q  <= dec_sw;
                bne_q <= dec_bne;
            end
        end
    end

    // Next-state and per-state datapath controls
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        PCwrite      = 1'b0;
        PCSource     = 2'b00;
        IorD         = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        MemToReg     = 1'b0;
        RegDest      = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUControl   = 3'b000;
        ShiftControl = 3'b000;
        ShiftToReg   = 1'b0;
        IllegalOp    = 1'b0;
        unique case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                ALUSrcB    = 2'b01;
                ALUControl = 3'b001;
                PCwrite    = 1'b1;
                cnt_d      = FW_LAST;
                state_d    = S_FWAIT;
            end
            S_FWAIT: begin
                if (cnt_q == 2'd0) begin
                    IRWrite = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = 3'b001;
                IllegalOp  = dec_ill;
                state_d    = dec_next;
            end
            S_EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUControl = alu_q;
                state_d    = S_WB_R;
            end
            S_WB_R: begin
                RegDest  = 1'b1;
                RegWrite = !(ovf_q && Overflow);
                state_d  = S_FETCH;
            end
            S_SH_LOAD: begin
                ShiftControl = 3'b001;
                state_d      = S_SH_EXEC;
            end
            S_SH_EXEC: begin
                ShiftControl = sh_q;
                state_d      = S_SH_WB;
            end
            S_SH_WB: begin
                ShiftToReg = 1'b1;
                RegDest    = 1'b1;
                RegWrite   = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDI_EX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 3'b001;
                state_d    = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite = !Overflow;
                state_d  = S_FETCH;
            end
            S_MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 3'b001;
                cnt_d      = LW_LAST;
                state_d    = sw_q ? S_SW_WR : S_LW_RD;
            end
            S_LW_RD: begin
                IorD = 1'b1;
                if (cnt_q == 2'd0) begin
                    state_d = S_LW_WB;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_LW_WB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_SW_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 3'b010;
                PCSource   = 2'b01;
                PCwrite    = bne_q ? !Zero : Zero;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCwrite  = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_RESET;
        endcase
    end

    assign State = state_q;

endmodule
